// File: rtl/serial_comparator_di.sv
// Bit-serial magnitude comparator: one LSB-first "less-than" cell evaluated per clock.
// Define SERIAL_CMP_SIGNED_EN to compare two's-complement operands instead of unsigned.
module serial_comparator_di #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             N
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CNT_W-1:0] cnt;
    logic             n;
    logic             e;
    logic             load;
    logic             step;
    logic             last;
    logic             a_bit;
    logic             b_bit;
    logic             n_next;
    logic             e_next;

    // The typical cell. In the signed build the MSB is a sign bit, so its
    // sense is inverted for the ordering term; equality uses raw bits.
    always_comb begin
        last = (cnt == LAST_CNT);
`ifdef SERIAL_CMP_SIGNED_EN
        a_bit = last ? ~sa[0] : sa[0];
        b_bit = last ? ~sb[0] : sb[0];
`else
        a_bit = sa[0];
        b_bit = sb[0];
`endif
        n_next = (n & (~a_bit | b_bit)) | (~a_bit & b_bit);
        e_next = e & ~(sa[0] ^ sb[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: operand shifters, chain/equality registers and held results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            cnt <= '0;
            n   <= 1'b0;
            e   <= 1'b0;
            lt  <= 1'b0;
            eq  <= 1'b0;
            gt  <= 1'b0;
        end else if (load) begin
            sa  <= A;
            sb  <= B;
            cnt <= '0;
            n   <= 1'b0;
            e   <= 1'b1;
        end else if (step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            cnt <= cnt + CNT_ONE;
            n   <= n_next;
            e   <= e_next;
            if (last) begin
                lt <= n_next;
                eq <= e_next;
                gt <= ~n_next & ~e_next;
            end
        end
    end

    assign N = n;

endmodule

// File: tb/tb_serial_comparator_di.sv
// Self-checking bench for serial_comparator_di: directed cases plus random operands
// checked against an arithmetic reference of the comparison and its partial chain.
module tb_serial_comparator_di;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic             n_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_comparator_di #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt),
        .N     (n_out)
    );

    // Full-width ordering, as plain arithmetic.
    function automatic logic model_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    // After 'bits' LSBs have been consumed, the chain equals "low bits of A < low bits of B".
    function automatic logic model_chain(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                         input int bits);
        int mask;
        if (bits >= WIDTH) return model_lt(a, b);
        mask = (1 << bits) - 1;
        return (int'(a) & mask) < (int'(b) & mask);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; start is sampled at the following rising edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Follows the WIDTH shift cycles and returns at the negedge of the done cycle.
    // pulse_edge > 0 drives a stray start (with zero operands) sampled at that edge.
    task automatic trackShift(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input int pulse_edge, input string tag);
        logic exp_lt;
        logic exp_eq;
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
            checkOutput($sformatf("%s_done%0d", tag, i), 32'(done), 32'd0);
            checkOutput($sformatf("%s_n%0d", tag, i), 32'(n_out), 32'(model_chain(a, b, i)));
            if (i + 1 == pulse_edge) begin
                start = 1'b1;
                a_in  = '0;
                b_in  = '0;
            end else begin
                start = 1'b0;
                a_in  = WIDTH'($urandom);
                b_in  = WIDTH'($urandom);
            end
            @(negedge clk);
        end
        start  = 1'b0;
        exp_lt = model_lt(a, b);
        exp_eq = (a == b);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_lt"}, 32'(lt), 32'(exp_lt));
        checkOutput({tag, "_eq"}, 32'(eq), 32'(exp_eq));
        checkOutput({tag, "_gt"}, 32'(gt), 32'(!exp_lt && !exp_eq));
        checkOutput({tag, "_nfinal"}, 32'(n_out), 32'(model_chain(a, b, WIDTH)));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             seen_done;
        int               gap;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_lt", 32'(lt), 32'd0);
        checkOutput("rst_eq", 32'(eq), 32'd0);
        checkOutput("rst_gt", 32'(gt), 32'd0);
        checkOutput("rst_n", 32'(n_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);

        $display("[TB] directed: 0x35 vs 0x36");
        applyStimulus(8'h35, 8'h36);
        trackShift(8'h35, 8'h36, 0, "c35_36");
        checkOutput("c35_36_lt_const", 32'(lt), 32'd1);
        @(negedge clk);
        checkOutput("hold_done", 32'(done), 32'd0);
        checkOutput("hold_busy", 32'(busy), 32'd0);
        checkOutput("hold_lt", 32'(lt), 32'd1);

        $display("[TB] directed: equal operands");
        applyStimulus(8'hA5, 8'hA5);
        trackShift(8'hA5, 8'hA5, 0, "cA5_A5");
        checkOutput("cA5_A5_eq_const", 32'(eq), 32'd1);
        @(negedge clk);

        $display("[TB] directed: sign-sensitive operands");
        applyStimulus(8'hFF, 8'h00);
        trackShift(8'hFF, 8'h00, 0, "cFF_00");
        @(negedge clk);
        applyStimulus(8'h80, 8'h7F);
        trackShift(8'h80, 8'h7F, 0, "c80_7F");
        @(negedge clk);

        $display("[TB] directed: start during shift is ignored");
        applyStimulus(8'h10, 8'h20);
        trackShift(8'h10, 8'h20, 3, "c10_20");
        checkOutput("c10_20_lt_const", 32'(lt), 32'd1);
        @(negedge clk);
        checkOutput("c10_20_back_idle", 32'(busy), 32'd0);

        $display("[TB] directed: back-to-back");
        applyStimulus(8'h01, 8'h00);
        trackShift(8'h01, 8'h00, 0, "b2b_first");
        checkOutput("b2b_first_gt_const", 32'(gt), 32'd1);
        applyStimulus(8'h00, 8'h01);
        trackShift(8'h00, 8'h01, 0, "b2b_second");
        checkOutput("b2b_second_lt_const", 32'(lt), 32'd1);
        @(negedge clk);

        $display("[TB] directed: asynchronous reset mid-shift");
        applyStimulus(8'h01, 8'h00);
        trackShift(8'h01, 8'h00, 0, "pre_rst");
        @(negedge clk);
        checkOutput("pre_rst_gt_held", 32'(gt), 32'd1);
        applyStimulus(8'h33, 8'h44);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_busy", 32'(busy), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_lt", 32'(lt), 32'd0);
        checkOutput("arst_eq", 32'(eq), 32'd0);
        checkOutput("arst_gt", 32'(gt), 32'd0);
        checkOutput("arst_n", 32'(n_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        checkOutput("arst_no_done", 32'(seen_done), 32'd0);
        applyStimulus(8'h5A, 8'h5B);
        trackShift(8'h5A, 8'h5B, 0, "post_rst");

        $display("[TB] random operands");
        for (int t = 0; t < 24; t++) begin
            ra = WIDTH'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
            applyStimulus(ra, rb);
            trackShift(ra, rb, 0, $sformatf("rnd%0d", t));
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
